// File: rtl/core_pkg.sv
// core_pkg: shared widths and instruction field layout for the 8-bit core
package core_pkg;
  localparam int PC_W = 5;
  localparam int INST_W = 8;
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] rd;
    logic [2:0] imm;
  } inst_t;
endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: instruction memory and decode-side signals of the fetch front end
interface ifetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W = core_pkg::PC_W,
  parameter int INST_W = core_pkg::INST_W
);
  logic [PC_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic redirect;
  logic [PC_W-1:0] redirect_pc;
  logic id_ready;
  logic if_valid;
  logic [INST_W-1:0] if_inst;
  logic [PC_W-1:0] if_pc;
  logic [$clog2(DEPTH):0] q_count;
  modport master (
    output imem_addr, if_valid, if_inst, if_pc, q_count,
    input imem_data, redirect, redirect_pc, id_ready
  );
  modport slave (
    input imem_addr, if_valid, if_inst, if_pc, q_count,
    output imem_data, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue storage with pointers, occupancy and synchronous flush
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 13,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: PC owner and prefetch queue feeding decode, flushed by redirects
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W = core_pkg::PC_W,
  parameter int INST_W = core_pkg::INST_W
) (
  input logic clk,
  input logic rst,
  ifetch_queue_if.master bus
);
  logic [PC_W-1:0] pc;
  logic push, pop, full, empty;
  assign bus.imem_addr = pc;
  assign bus.if_valid = !empty;
  assign pop = bus.if_valid && bus.id_ready;
  assign push = !bus.redirect && (!full || pop);
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc <= '0;
    else if (bus.redirect) pc <= bus.redirect_pc;
    else if (push) pc <= pc + 1'b1;
  fetch_fifo #(.DEPTH(DEPTH), .W(PC_W + INST_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(bus.redirect),
    .push(push),
    .pop(pop && !bus.redirect),
    .din({pc, bus.imem_data}),
    .dout({bus.if_pc, bus.if_inst}),
    .count(bus.q_count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenario checks of the fetch front end
module tb_ifetch_queue;
  logic clk = 0;
  logic rst = 0;
  int pass_cnt = 0;
  int total = 0;
  ifetch_queue_if #(.DEPTH(4), .PC_W(5), .INST_W(8)) bus ();
  ifetch_queue #(.DEPTH(4), .PC_W(5), .INST_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_data = 8'h10 + {3'b000, bus.imem_addr};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bus.redirect = 0;
    bus.redirect_pc = '0;
    bus.id_ready = 0;
    #1;
    chk("reset q_count", int'(bus.q_count), 0);
    chk("reset if_valid", int'(bus.if_valid), 0);
    chk("reset imem_addr", int'(bus.imem_addr), 0);
    chk("reset if_pc", int'(bus.if_pc), 0);
    chk("reset if_inst", int'(bus.if_inst), 0);
    rst = 1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("fill q_count", int'(bus.q_count), i);
    end
    chk("fill if_pc", int'(bus.if_pc), 0);
    chk("fill if_inst", int'(bus.if_inst), 8'h10);
    chk("fill imem_addr", int'(bus.imem_addr), 4);
    step();
    chk("stall imem_addr", int'(bus.imem_addr), 4);
    chk("stall q_count", int'(bus.q_count), 4);
  endtask

  task automatic test_full_pop();
    bus.id_ready = 1;
    step();
    bus.id_ready = 0;
    chk("fullpop q_count", int'(bus.q_count), 4);
    chk("fullpop if_pc", int'(bus.if_pc), 1);
    chk("fullpop if_inst", int'(bus.if_inst), 8'h11);
    chk("fullpop imem_addr", int'(bus.imem_addr), 5);
    step();
    chk("fullpop hold addr", int'(bus.imem_addr), 5);
  endtask

  task automatic test_stream();
    bus.redirect = 1;
    bus.redirect_pc = 5'd0;
    step();
    bus.redirect = 0;
    bus.id_ready = 1;
    step();
    for (int i = 0; i < 34; i++) begin
      chk("stream if_valid", int'(bus.if_valid), 1);
      chk("stream if_pc", int'(bus.if_pc), i % 32);
      chk("stream if_inst", int'(bus.if_inst), 8'h10 + (i % 32));
      chk("stream q_count", int'(bus.q_count), 1);
      step();
    end
  endtask

  task automatic test_redirect_flush();
    bus.id_ready = 0;
    step();
    step();
    chk("flush pre q_count", int'(bus.q_count), 3);
    bus.redirect = 1;
    bus.redirect_pc = 5'd20;
    bus.id_ready = 1;
    step();
    bus.redirect = 0;
    bus.id_ready = 0;
    chk("flush if_valid", int'(bus.if_valid), 0);
    chk("flush q_count", int'(bus.q_count), 0);
    chk("flush imem_addr", int'(bus.imem_addr), 20);
    step();
    chk("flush tgt valid", int'(bus.if_valid), 1);
    chk("flush tgt if_pc", int'(bus.if_pc), 20);
    chk("flush tgt if_inst", int'(bus.if_inst), 8'h24);
    chk("flush tgt q_count", int'(bus.q_count), 1);
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    bus.id_ready = 1;
    bus.redirect = 1;
    bus.redirect_pc = 5'd7;
    step();
    chk("b2b first valid", int'(bus.if_valid), 0);
    chk("b2b first addr", int'(bus.imem_addr), 7);
    bus.redirect_pc = 5'd12;
    step();
    bus.redirect = 0;
    chk("b2b second valid", int'(bus.if_valid), 0);
    chk("b2b second addr", int'(bus.imem_addr), 12);
    for (int i = 0; i < 4 && !seen; i++) begin
      step();
      if (bus.if_valid) begin
        seen = 1;
        chk("b2b head pc", int'(bus.if_pc), 12);
        chk("b2b head inst", int'(bus.if_inst), 8'h1C);
      end
    end
    chk("b2b head seen", int'(seen), 1);
    bus.id_ready = 0;
  endtask

  task automatic test_async_reset();
    bus.redirect = 1;
    bus.redirect_pc = 5'd0;
    step();
    bus.redirect = 0;
    step();
    step();
    chk("areset pre q_count", int'(bus.q_count), 2);
    #2;
    rst = 0;
    #1;
    chk("areset q_count", int'(bus.q_count), 0);
    chk("areset if_valid", int'(bus.if_valid), 0);
    chk("areset imem_addr", int'(bus.imem_addr), 0);
    chk("areset if_pc", int'(bus.if_pc), 0);
    chk("areset if_inst", int'(bus.if_inst), 0);
    #2;
    rst = 1;
    step();
    chk("areset resume q_count", int'(bus.q_count), 1);
    chk("areset resume if_pc", int'(bus.if_pc), 0);
    chk("areset resume if_inst", int'(bus.if_inst), 8'h10);
    chk("areset resume addr", int'(bus.imem_addr), 1);
  endtask

  initial begin
    test_reset();
    test_full_pop();
    test_stream();
    test_redirect_flush();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
